galvo_dac_streamer: RTL

Consumes the periodic `strobe_out` pulse of the galvo update-rate generator and, on each pulse, pops one (x, y, laser) point from an internal FIFO and writes it to the dual-channel 12-bit galvo DAC (MCP4922-style SPI, shared LDAC). Sits between the point source (frame/pinball renderer) and the galvo/laser hardware pins. Laser enable is updated on the same LDAC edge as the mirror positions, so beam and mirrors switch together.

---
 rtl/galvo_dac_streamer.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/galvo_dac_streamer.sv
// Point FIFO feeding a dual-channel 12-bit SPI galvo DAC; one point is written per update strobe.
// The laser enable is latched on the same LDAC edge that moves the mirrors.
module galvo_dac_streamer #(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned SCLK_DIV   = 4,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              strobe_in,
  input  logic              pt_valid,
  output logic              pt_ready,
  input  logic [DATA_W-1:0] pt_x,
  input  logic [DATA_W-1:0] pt_y,
  input  logic              pt_laser,
  output logic              dac_cs_n,
  output logic              dac_sclk,
  output logic              dac_sdi,
  output logic              dac_ldac_n,
  output logic              laser_on,
  output logic              busy,
  output logic              underrun,
  output logic              strobe_missed
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned DivW  = $clog2(SCLK_DIV + 1);
  localparam int unsigned EntW  = 2 * DATA_W + 1;

  localparam logic [CntW-1:0] Full    = CntW'(FIFO_DEPTH);
  localparam logic [DivW-1:0] DivLast = DivW'(SCLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShiftA,
    StGap,
    StShiftB,
    StLdac
  } state_e;

  // Left-align a DATA_W code into the DAC's 12 data bits, zero-padding the LSBs.
  function automatic logic [11:0] align(input logic [DATA_W-1:0] v);
    logic [DATA_W+11:0] w;
    w = {v, 12'b0};
    return w[DATA_W+11 -: 12];
  endfunction

  // ---------------------------------------------------------------------------
  // Point FIFO
  // ---------------------------------------------------------------------------
  logic [EntW-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            fifo_empty;
  logic            push, pop;
  logic [EntW-1:0] head;

  assign fifo_empty = (count_q == '0);
  assign pt_ready   = (count_q != Full);
  assign push       = pt_valid && pt_ready;
  assign head       = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {pt_laser, pt_x, pt_y};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Transfer sequencer
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic              phase_q, phase_d;
  logic [3:0]        bit_q, bit_d;
  logic [15:0]       sh_q, sh_d;
  logic [DATA_W-1:0] x_q, x_d, y_q, y_d;
  logic              hold_q, hold_d;
  logic              laser_q, laser_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic              sdi_q, sdi_d;
  logic              ldac_n_q, ldac_n_d;
  logic              underrun_q, underrun_d;
  logic              missed_q, missed_d;
  logic              div_last;
  logic              shifting_d;

  assign div_last = (div_q == DivLast);
  assign pop      = (state_q == StIdle) && strobe_in && !fifo_empty;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    x_d        = x_q;
    y_d        = y_q;
    hold_d     = hold_q;
    laser_d    = laser_q;
    underrun_d = 1'b0;
    missed_d   = strobe_in && (state_q != StIdle);

    case (state_q)
      StIdle: begin
        if (strobe_in) begin
          if (!fifo_empty) begin
            hold_d  = head[EntW-1];
            x_d     = head[EntW-2 -: DATA_W];
            y_d     = head[DATA_W-1:0];
            state_d = StLoad;
          end else begin
            // Nothing to draw: blank the beam, leave the mirrors where they are.
            underrun_d = 1'b1;
            laser_d    = 1'b0;
          end
        end
      end
      StLoad: begin
        sh_d    = {4'b0011, align(x_q)};
        div_d   = '0;
        phase_d = 1'b0;
        bit_d   = '0;
        state_d = StShiftA;
      end
      StShiftA, StShiftB: begin
        if (div_last) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            sh_d    = {sh_q[14:0], 1'b0};
            if (bit_q == 4'd15) begin
              bit_d   = '0;
              state_d = (state_q == StShiftA) ? StGap : StLdac;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StGap: begin
        if (div_last) begin
          div_d   = '0;
          sh_d    = {4'b1011, align(y_q)};
          state_d = StShiftB;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StLdac: begin
        if (div_last) begin
          div_d   = '0;
          state_d = StIdle;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Pin values are registered from the next state so they line up with it exactly.
    shifting_d = (state_d == StShiftA) || (state_d == StShiftB);
    cs_n_d     = !shifting_d;
    sclk_d     = shifting_d && phase_d;
    sdi_d      = shifting_d && sh_d[15];
    ldac_n_d   = (state_d != StLdac);
    if ((state_d == StLdac) && (state_q != StLdac)) begin
      laser_d = hold_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      div_q      <= '0;
      phase_q    <= 1'b0;
      bit_q      <= '0;
      sh_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      hold_q     <= 1'b0;
      laser_q    <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      sdi_q      <= 1'b0;
      ldac_n_q   <= 1'b1;
      underrun_q <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      x_q        <= x_d;
      y_q        <= y_d;
      hold_q     <= hold_d;
      laser_q    <= laser_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      sdi_q      <= sdi_d;
      ldac_n_q   <= ldac_n_d;
      underrun_q <= underrun_d;
      missed_q   <= missed_d;
    end
  end

  assign dac_cs_n      = cs_n_q;
  assign dac_sclk      = sclk_q;
  assign dac_sdi       = sdi_q;
  assign dac_ldac_n    = ldac_n_q;
  assign laser_on      = laser_q;
  assign busy          = (state_q != StIdle);
  assign underrun      = underrun_q;
  assign strobe_missed = missed_q;

endmodule
